// File: rtl/dma_loop_sequencer_if.sv
// Descriptor and completion-status signals between the loop sequencer and the
// loopback DMA pair (S2MM write engine, MM2S read engine).
interface dma_loop_sequencer_if #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_LEN_WIDTH   = 32,
  parameter int AXIS_USER_WIDTH = 8,
  parameter int TAG_WIDTH       = 8
);
  logic [AXI_ADDR_WIDTH+AXI_LEN_WIDTH-1:0] s2mm_desc;
  logic [TAG_WIDTH-1:0]                    s2mm_tag;
  logic                                    s2mm_valid;
  logic                                    s2mm_ready;
  logic [TAG_WIDTH-1:0]                    s2mm_status_tag;
  logic [3:0]                              s2mm_status_error;
  logic                                    s2mm_status_valid;

  logic [AXI_ADDR_WIDTH+AXI_LEN_WIDTH-1:0] mm2s_desc;
  logic [AXIS_USER_WIDTH-1:0]              mm2s_user;
  logic                                    mm2s_valid;
  logic                                    mm2s_ready;
  logic [3:0]                              mm2s_status_error;
  logic                                    mm2s_status_valid;

  modport master (
    output s2mm_desc, s2mm_tag, s2mm_valid,
    input  s2mm_ready, s2mm_status_tag, s2mm_status_error, s2mm_status_valid,
    output mm2s_desc, mm2s_user, mm2s_valid,
    input  mm2s_ready, mm2s_status_error, mm2s_status_valid
  );

  modport slave (
    input  s2mm_desc, s2mm_tag, s2mm_valid,
    output s2mm_ready, s2mm_status_tag, s2mm_status_error, s2mm_status_valid,
    input  mm2s_desc, mm2s_user, mm2s_valid,
    output mm2s_ready, mm2s_status_error, mm2s_status_valid
  );
endinterface

// File: rtl/dma_loop_sequencer.sv
// Runs a multi-iteration loopback transfer: per iteration one S2MM descriptor,
// one MM2S descriptor, then both completions; addresses advance by a stride.
//
// state    | meaning
// IDLE     | waiting for cfg_start
// ISSUE_WR | presenting the S2MM descriptor
// ISSUE_RD | presenting the MM2S descriptor
// WAIT     | collecting both completion statuses
// FINISH   | emitting the done pulse
module dma_loop_sequencer #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_LEN_WIDTH   = 32,
  parameter int AXIS_USER_WIDTH = 8,
  parameter int TAG_WIDTH       = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       cfg_start,
  input  logic                       cfg_abort,
  input  logic [AXI_ADDR_WIDTH-1:0]  cfg_src_addr,
  input  logic [AXI_ADDR_WIDTH-1:0]  cfg_dst_addr,
  input  logic [AXI_LEN_WIDTH-1:0]   cfg_len,
  input  logic [AXI_ADDR_WIDTH-1:0]  cfg_stride,
  input  logic [CNT_WIDTH-1:0]       cfg_count,
  input  logic [AXIS_USER_WIDTH-1:0] cfg_user,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_WIDTH-1:0]       iter_done,
  output logic [CNT_WIDTH-1:0]       err_count,
  output logic [3:0]                 last_error,
  dma_loop_sequencer_if.master       dma
);

  localparam int DW = AXI_ADDR_WIDTH + AXI_LEN_WIDTH;

  typedef enum logic [2:0] {IDLE, ISSUE_WR, ISSUE_RD, WAIT, FINISH} state_t;

  state_t                     state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]  src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
  logic [AXI_ADDR_WIDTH-1:0]  stride_q, stride_d;
  logic [AXI_LEN_WIDTH-1:0]   len_q, len_d;
  logic [CNT_WIDTH-1:0]       count_q, count_d;
  logic                       wr_seen_q, wr_seen_d, rd_seen_q, rd_seen_d;
  logic                       busy_q, busy_d, done_q, done_d;
  logic [CNT_WIDTH-1:0]       iter_done_q, iter_done_d, err_count_q, err_count_d;
  logic [3:0]                 last_error_q, last_error_d;
  logic [DW-1:0]              s2mm_desc_q, s2mm_desc_d, mm2s_desc_q, mm2s_desc_d;
  logic [TAG_WIDTH-1:0]       s2mm_tag_q, s2mm_tag_d;
  logic                       s2mm_valid_q, s2mm_valid_d, mm2s_valid_q, mm2s_valid_d;
  logic [AXIS_USER_WIDTH-1:0] mm2s_user_q, mm2s_user_d;

  logic                      wr_hit, rd_hit, tag_bad, wr_err, rd_err;
  logic [3:0]                wr_code;
  logic [1:0]                n_err;
  logic [CNT_WIDTH:0]        err_sum;
  logic [CNT_WIDTH-1:0]      iter_next;
  logic [AXI_ADDR_WIDTH-1:0] src_next, dst_next;

  always_comb begin
    // Strobes only matter while collecting statuses; elsewhere they are dropped.
    wr_hit    = (state_q == WAIT) && dma.s2mm_status_valid;
    rd_hit    = (state_q == WAIT) && dma.mm2s_status_valid;
    tag_bad   = dma.s2mm_status_tag != TAG_WIDTH'(iter_done_q);
    wr_code   = tag_bad ? 4'hF : dma.s2mm_status_error;
    wr_err    = wr_hit && (wr_code != 4'h0);
    rd_err    = rd_hit && (dma.mm2s_status_error != 4'h0);
    n_err     = {1'b0, wr_err} + {1'b0, rd_err};
    err_sum   = {1'b0, err_count_q} + {{(CNT_WIDTH-1){1'b0}}, n_err};
    iter_next = iter_done_q + 1'b1;
    src_next  = src_ptr_q + stride_q;
    dst_next  = dst_ptr_q + stride_q;

    state_d      = state_q;
    src_ptr_d    = src_ptr_q;
    dst_ptr_d    = dst_ptr_q;
    stride_d     = stride_q;
    len_d        = len_q;
    count_d      = count_q;
    wr_seen_d    = wr_seen_q;
    rd_seen_d    = rd_seen_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    iter_done_d  = iter_done_q;
    err_count_d  = err_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : err_sum[CNT_WIDTH-1:0];
    last_error_d = wr_err ? wr_code : (rd_err ? dma.mm2s_status_error : last_error_q);
    s2mm_desc_d  = s2mm_desc_q;
    s2mm_tag_d   = s2mm_tag_q;
    s2mm_valid_d = s2mm_valid_q;
    mm2s_desc_d  = mm2s_desc_q;
    mm2s_valid_d = mm2s_valid_q;
    mm2s_user_d  = mm2s_user_q;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          src_ptr_d    = cfg_src_addr;
          dst_ptr_d    = cfg_dst_addr;
          stride_d     = cfg_stride;
          len_d        = cfg_len;
          count_d      = cfg_count;
          mm2s_user_d  = cfg_user;
          iter_done_d  = '0;
          err_count_d  = '0;
          last_error_d = 4'h0;
          wr_seen_d    = 1'b0;
          rd_seen_d    = 1'b0;
          busy_d       = 1'b1;
          if ((cfg_count == '0) || (cfg_len == '0)) begin
            state_d = FINISH;
          end else begin
            state_d      = ISSUE_WR;
            s2mm_valid_d = 1'b1;
            s2mm_desc_d  = {cfg_len, cfg_dst_addr};
            s2mm_tag_d   = '0;
          end
        end
      end
      ISSUE_WR: begin
        if (dma.s2mm_ready) begin
          state_d      = ISSUE_RD;
          s2mm_valid_d = 1'b0;
          mm2s_valid_d = 1'b1;
          mm2s_desc_d  = {len_q, src_ptr_q};
        end
      end
      ISSUE_RD: begin
        if (dma.mm2s_ready) begin
          state_d      = WAIT;
          mm2s_valid_d = 1'b0;
        end
      end
      WAIT: begin
        wr_seen_d = wr_seen_q | wr_hit;
        rd_seen_d = rd_seen_q | rd_hit;
        if ((wr_seen_q | wr_hit) && (rd_seen_q | rd_hit)) begin
          iter_done_d = iter_next;
          src_ptr_d   = src_next;
          dst_ptr_d   = dst_next;
          wr_seen_d   = 1'b0;
          rd_seen_d   = 1'b0;
          if ((iter_next == count_q) || cfg_abort) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d      = ISSUE_WR;
            s2mm_valid_d = 1'b1;
            s2mm_desc_d  = {len_q, dst_next};
            s2mm_tag_d   = TAG_WIDTH'(iter_next);
          end
        end
      end
      FINISH: begin
        // A degenerate start arrives here with done still low, so it pulses one cycle later.
        if (done_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      stride_q     <= '0;
      len_q        <= '0;
      count_q      <= '0;
      wr_seen_q    <= 1'b0;
      rd_seen_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      iter_done_q  <= '0;
      err_count_q  <= '0;
      last_error_q <= 4'h0;
      s2mm_desc_q  <= '0;
      s2mm_tag_q   <= '0;
      s2mm_valid_q <= 1'b0;
      mm2s_desc_q  <= '0;
      mm2s_valid_q <= 1'b0;
      mm2s_user_q  <= '0;
    end else begin
      state_q      <= state_d;
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      stride_q     <= stride_d;
      len_q        <= len_d;
      count_q      <= count_d;
      wr_seen_q    <= wr_seen_d;
      rd_seen_q    <= rd_seen_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      iter_done_q  <= iter_done_d;
      err_count_q  <= err_count_d;
      last_error_q <= last_error_d;
      s2mm_desc_q  <= s2mm_desc_d;
      s2mm_tag_q   <= s2mm_tag_d;
      s2mm_valid_q <= s2mm_valid_d;
      mm2s_desc_q  <= mm2s_desc_d;
      mm2s_valid_q <= mm2s_valid_d;
      mm2s_user_q  <= mm2s_user_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign iter_done      = iter_done_q;
  assign err_count      = err_count_q;
  assign last_error     = last_error_q;
  assign dma.s2mm_desc  = s2mm_desc_q;
  assign dma.s2mm_tag   = s2mm_tag_q;
  assign dma.s2mm_valid = s2mm_valid_q;
  assign dma.mm2s_desc  = mm2s_desc_q;
  assign dma.mm2s_user  = mm2s_user_q;
  assign dma.mm2s_valid = mm2s_valid_q;

endmodule

// File: tb/tb_dma_loop_sequencer.sv
// Bench for dma_loop_sequencer: table of configurations, hand-built corner
// sequences and randomized runs against an address/error model.
module tb_dma_loop_sequencer;
  localparam int AW = 32, LW = 32, UW = 8, TW = 8, CW = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [AW-1:0] cfg_src_addr = '0, cfg_dst_addr = '0, cfg_stride = '0;
  logic [LW-1:0] cfg_len = '0;
  logic [CW-1:0] cfg_count = '0;
  logic [UW-1:0] cfg_user = '0;
  logic          busy, done;
  logic [CW-1:0] iter_done, err_count;
  logic [3:0]    last_error;

  dma_loop_sequencer_if #(.AXI_ADDR_WIDTH(AW), .AXI_LEN_WIDTH(LW),
                          .AXIS_USER_WIDTH(UW), .TAG_WIDTH(TW)) dif ();

  dma_loop_sequencer #(.AXI_ADDR_WIDTH(AW), .AXI_LEN_WIDTH(LW), .AXIS_USER_WIDTH(UW),
                       .TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr), .cfg_len(cfg_len),
    .cfg_stride(cfg_stride), .cfg_count(cfg_count), .cfg_user(cfg_user),
    .busy(busy), .done(done), .iter_done(iter_done), .err_count(err_count),
    .last_error(last_error), .dma(dif)
  );

  int errors = 0, checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: programmed configuration and expected error accounting.
  logic [AW-1:0] m_src, m_dst, m_stride;
  logic [LW-1:0] m_len;
  logic [CW-1:0] m_count;
  logic [UW-1:0] m_user;
  logic [CW-1:0] m_err;
  logic [3:0]    m_last;
  int n_s2mm, n_mm2s, n_done, st_iter, last_pair_cyc, s2mm_hs_cyc, first_hs_cyc;
  logic [AW-1:0] last_dst, last_src;

  // Knobs
  int rdy_mode = 0, hold_left = 0, st_mode = 1, err_mode = 0, abort_iter = -1;
  bit start_while_busy = 0;

  task automatic setup_model(input logic [AW-1:0] src, dst, stride, input logic [LW-1:0] len,
                             input logic [CW-1:0] count, input logic [UW-1:0] user);
    m_src = src; m_dst = dst; m_stride = stride; m_len = len; m_count = count; m_user = user;
    m_err = '0; m_last = 4'h0;
    n_s2mm = 0; n_mm2s = 0; n_done = 0; st_iter = 0; first_hs_cyc = -1;
    last_dst = '0; last_src = '0;
  endtask

  // Monitor: descriptor contents, handshake stability and latency.
  logic          s2mm_pend = 0, mm2s_pend = 0, p_mm2s_valid = 0;
  logic [63:0]   p_s2mm_desc, p_mm2s_desc;
  logic [AW-1:0] exp_a;
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (s2mm_pend) begin
        chk("s2mm_valid_held", dif.s2mm_valid, 1'b1);
        chk("s2mm_desc_stable", dif.s2mm_desc, p_s2mm_desc);
      end
      if (mm2s_pend) begin
        chk("mm2s_valid_held", dif.mm2s_valid, 1'b1);
        chk("mm2s_desc_stable", dif.mm2s_desc, p_mm2s_desc);
      end
      if (dif.s2mm_valid) chk("no_dual_valid", dif.mm2s_valid, 1'b0);
      if (dif.mm2s_valid && !p_mm2s_valid) chk("mm2s_rise_latency", cyc, s2mm_hs_cyc + 1);
      if (dif.s2mm_valid && dif.s2mm_ready) begin
        exp_a = m_dst + AW'(n_s2mm) * m_stride;
        chk("s2mm_extra_desc", n_s2mm < int'(m_count), 1'b1);
        chk("s2mm_desc", dif.s2mm_desc, {m_len, exp_a});
        chk("s2mm_tag", dif.s2mm_tag, TW'(n_s2mm));
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_dst = dif.s2mm_desc[AW-1:0];
        s2mm_hs_cyc = cyc;
        n_s2mm++;
      end
      if (dif.mm2s_valid && dif.mm2s_ready) begin
        exp_a = m_src + AW'(n_mm2s) * m_stride;
        chk("mm2s_desc", dif.mm2s_desc, {m_len, exp_a});
        chk("mm2s_user", dif.mm2s_user, m_user);
        last_src = dif.mm2s_desc[AW-1:0];
        n_mm2s++;
      end
      if (done) n_done++;
      s2mm_pend    = dif.s2mm_valid && !dif.s2mm_ready;
      mm2s_pend    = dif.mm2s_valid && !dif.mm2s_ready;
      p_s2mm_desc  = dif.s2mm_desc;
      p_mm2s_desc  = dif.mm2s_desc;
      p_mm2s_valid = dif.mm2s_valid;
    end else begin
      s2mm_pend = 0; mm2s_pend = 0; p_mm2s_valid = 0;
    end
  end

  // Ready driver
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: begin dif.s2mm_ready = 1'b1; dif.mm2s_ready = 1'b1; end
      1: begin dif.s2mm_ready = 1'($urandom_range(0, 1)); dif.mm2s_ready = 1'($urandom_range(0, 1)); end
      default: begin
        dif.s2mm_ready = (hold_left == 0);
        dif.mm2s_ready = 1'b1;
        if (hold_left > 0 && dif.s2mm_valid) hold_left--;
      end
    endcase
  end

  // Status responder: after each MM2S handshake return both completions and
  // update the expected error count (same-cycle pair: S2MM code is the latest).
  int dw, dr, mx;
  logic [3:0] cw, cr, wcode;
  bit bad;
  initial forever begin
    @(negedge clk);
    if (rstn && dif.mm2s_valid && dif.mm2s_ready) begin
      case (st_mode)
        0: begin dw = $urandom_range(1, 6); dr = $urandom_range(1, 6); end
        2: begin dw = (st_iter == 0) ? 4 : 3; dr = (st_iter == 0) ? 2 : 3; end
        default: begin dw = 5; dr = 5; end
      endcase
      mx = (dw > dr) ? dw : dr;
      cw = 4'h0; cr = 4'h0; bad = 0;
      if (err_mode == 1) begin
        if ($urandom_range(0, 3) == 0) cw = 4'($urandom_range(1, 15));
        if ($urandom_range(0, 3) == 0) cr = 4'($urandom_range(1, 15));
        bad = ($urandom_range(0, 5) == 0);
      end else if (err_mode == 2) begin
        if (st_iter == 0) cr = 4'h2;
        if (st_iter == 1) bad = 1;
      end
      wcode = bad ? 4'hF : cw;
      if (abort_iter == st_iter) cfg_abort = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= mx; k++) begin
        #1;
        dif.s2mm_status_valid = (k == dw);
        dif.s2mm_status_tag   = bad ? (TW'(st_iter) ^ 8'hA5) : TW'(st_iter);
        dif.s2mm_status_error = cw;
        dif.mm2s_status_valid = (k == dr);
        dif.mm2s_status_error = cr;
        if (start_while_busy && st_iter == 0) cfg_start = (k == 1);
        if (k == dr && cr != 4'h0) begin
          if (m_err != '1) m_err++;
          m_last = cr;
        end
        if (k == dw && wcode != 4'h0) begin
          if (m_err != '1) m_err++;
          m_last = wcode;
        end
        @(posedge clk);
      end
      #1;
      dif.s2mm_status_valid = 1'b0;
      dif.mm2s_status_valid = 1'b0;
      if (start_while_busy && st_iter == 0) cfg_start = 1'b0;
      last_pair_cyc = cyc;
      st_iter++;
    end
  end

  int t0;
  task automatic pulse_start(input logic [AW-1:0] src, dst, stride, input logic [LW-1:0] len,
                             input logic [CW-1:0] count, input logic [UW-1:0] user);
    setup_model(src, dst, stride, len, count, user);
    @(posedge clk); #1;
    cfg_src_addr = src; cfg_dst_addr = dst; cfg_stride = stride;
    cfg_len = len; cfg_count = count; cfg_user = user; cfg_start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    // Scramble inputs to prove the configuration was latched.
    cfg_src_addr = $urandom; cfg_dst_addr = $urandom; cfg_stride = $urandom;
    cfg_len = $urandom; cfg_count = CW'($urandom); cfg_user = UW'($urandom);
  endtask

  task automatic run_seq(input string nm, input logic [AW-1:0] src, dst, stride,
                         input logic [LW-1:0] len, input logic [CW-1:0] count,
                         input logic [UW-1:0] user, input int exp_iters);
    bit degen, got;
    int done_cyc;
    degen = (count == 0) || (len == 0);
    pulse_start(src, dst, stride, len, count, user);
    @(negedge clk);
    chk({nm, ":busy_t+1"}, busy, 1'b1);
    if (rdy_mode == 0) chk({nm, ":s2mm_valid_t+1"}, dif.s2mm_valid, !degen);
    got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    chk({nm, ":done_seen"}, got, 1'b1);
    done_cyc = cyc;
    if (degen) chk({nm, ":done_at_t+2"}, done_cyc, t0 + 2);
    else       chk({nm, ":done_after_pair"}, done_cyc, last_pair_cyc);
    chk({nm, ":busy_at_done"}, busy, 1'b1);
    chk({nm, ":iter_done"}, iter_done, exp_iters);
    chk({nm, ":err_count"}, err_count, m_err);
    chk({nm, ":last_error"}, last_error, m_last);
    @(negedge clk);
    chk({nm, ":busy_cleared"}, busy, 1'b0);
    chk({nm, ":done_one_cycle"}, done, 1'b0);
    repeat (3) @(negedge clk);
    chk({nm, ":done_pulses"}, n_done, 1);
    chk({nm, ":s2mm_descs"}, n_s2mm, exp_iters);
    chk({nm, ":mm2s_descs"}, n_mm2s, exp_iters);
  endtask

  typedef struct {
    logic [AW-1:0] src, dst, stride;
    logic [LW-1:0] len;
    logic [CW-1:0] count;
    int            exp_iters;
    logic [AW-1:0] exp_last_dst, exp_last_src;
  } vec_t;
  vec_t tbl[5];

  logic [CW-1:0] rc;
  logic [LW-1:0] rl;
  bit            got_w;

  initial begin
    dif.s2mm_ready = 1'b1; dif.mm2s_ready = 1'b1;
    dif.s2mm_status_valid = 1'b0; dif.mm2s_status_valid = 1'b0;
    dif.s2mm_status_tag = '0; dif.s2mm_status_error = '0; dif.mm2s_status_error = '0;
    setup_model('0, '0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_valids", {dif.s2mm_valid, dif.mm2s_valid}, 2'b00);
    chk("rst_counters", {iter_done, err_count, last_error}, '0);
    chk("rst_desc_tag_user", {dif.s2mm_desc ^ dif.mm2s_desc, dif.s2mm_tag, dif.mm2s_user}, '0);
    chk("rst_s2mm_desc", dif.s2mm_desc, '0);
    rstn = 1'b1;

    tbl[0] = '{32'h1000, 32'h8000, 32'h100, 256, 3, 3, 32'h8200, 32'h1200};
    tbl[1] = '{32'h1000, 32'h8000, 32'h100, 256, 0, 0, 32'h0, 32'h0};
    tbl[2] = '{32'h1000, 32'h8000, 32'h100, 0, 4, 0, 32'h0, 32'h0};
    tbl[3] = '{32'h10, 32'hFFFFFF00, 32'h100, 64, 2, 2, 32'h0, 32'h110};
    tbl[4] = '{32'h40000000, 32'h2000, 32'h40, 8, 1, 1, 32'h2000, 32'h40000000};
    rdy_mode = 0; st_mode = 1; err_mode = 0;
    for (int i = 0; i < 5; i++) begin
      run_seq($sformatf("tbl%0d", i), tbl[i].src, tbl[i].dst, tbl[i].stride, tbl[i].len,
              tbl[i].count, 8'h3C, tbl[i].exp_iters);
      if (tbl[i].exp_iters > 0) begin
        chk($sformatf("tbl%0d:last_dst", i), last_dst, tbl[i].exp_last_dst);
        chk($sformatf("tbl%0d:last_src", i), last_src, tbl[i].exp_last_src);
      end
    end

    // S2MM ready held low for 10 cycles on the first descriptor.
    rdy_mode = 2; hold_left = 10;
    run_seq("hold", 32'h100, 32'h200, 32'h20, 16, 2, 8'h11, 2);
    chk("hold:first_hs_cycle", first_hs_cyc, t0 + 11);
    rdy_mode = 0;

    // MM2S status first, then both in the same cycle.
    st_mode = 2;
    run_seq("order", 32'h0, 32'h4000, 32'h80, 32, 2, 8'h22, 2);
    st_mode = 1;

    // Read error on iteration 0, wrong tag on iteration 1.
    err_mode = 2;
    run_seq("errs", 32'h0, 32'h4000, 32'h80, 32, 3, 8'h33, 3);
    chk("errs:err_count_const", err_count, 2);
    chk("errs:last_error_const", last_error, 4'hF);
    err_mode = 0;

    // Abort during iteration 1 of 5, with a start pulse while busy.
    abort_iter = 1; start_while_busy = 1;
    run_seq("abort", 32'h500, 32'h900, 32'h10, 4, 5, 8'h44, 2);
    abort_iter = -1; start_while_busy = 0;
    @(posedge clk); #1; cfg_abort = 1'b0;

    // Reset while waiting for statuses.
    pulse_start(32'h1000, 32'h8000, 32'h100, 256, 3, 8'h55);
    got_w = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_mm2s >= 1) begin got_w = 1; break; end
    end
    chk("rst_mid:reached_wait", got_w, 1'b1);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("rst_mid:busy", busy, 1'b0);
    chk("rst_mid:valids", {dif.s2mm_valid, dif.mm2s_valid, done}, 3'b000);
    chk("rst_mid:counters", {iter_done, err_count, last_error}, '0);
    chk("rst_mid:desc", {dif.s2mm_desc | dif.mm2s_desc}, '0);
    chk("rst_mid:tag_user", {dif.s2mm_tag, dif.mm2s_user}, '0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_mid:no_reissue", {dif.s2mm_valid, dif.mm2s_valid, busy}, 3'b000);
    end
    run_seq("after_rst", 32'h1000, 32'h8000, 32'h100, 256, 3, 8'h66, 3);

    // Randomized sequences.
    rdy_mode = 1; st_mode = 0; err_mode = 1;
    for (int n = 0; n < 20; n++) begin
      rc = CW'($urandom_range(0, 5));
      rl = ($urandom_range(0, 7) == 0) ? '0 : LW'($urandom);
      run_seq($sformatf("rnd%0d", n), $urandom, $urandom, $urandom, rl, rc,
              UW'($urandom), (rl == 0) ? 0 : int'(rc));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dma_loop_sequencer.md
# dma_loop_sequencer

Sequences the loopback DMA pair so software can request a multi-iteration transfer with one register write. For each iteration it issues an S2MM (write) descriptor, then an MM2S (read) descriptor, then waits for both completion statuses. It advances the source and destination addresses by a stride between iterations and reports progress and errors. It sits between the AXI-Lite register decode and the two descriptor/status ports of the read and write DMA engines.

## Interface
- AXI_ADDR_WIDTH, 32, byte address width of descriptors
- AXI_LEN_WIDTH, 32, byte length field width
- AXIS_USER_WIDTH, 8, tuser passed on MM2S descriptors
- TAG_WIDTH, 8, S2MM descriptor/status tag width
- CNT_WIDTH, 16, iteration and error counter width

Ports:
- clk  in  1  single clock
- rstn  in  1  reset, asynchronous assert, active-low
- cfg_start  in  1  one-cycle start pulse
- cfg_abort  in  1  level; stop after the current iteration
- cfg_src_addr  in  AXI_ADDR_WIDTH  MM2S base address
- cfg_dst_addr  in  AXI_ADDR_WIDTH  S2MM base address
- cfg_len  in  AXI_LEN_WIDTH  bytes per iteration
- cfg_stride  in  AXI_ADDR_WIDTH  address increment per iteration, both sides
- cfg_count  in  CNT_WIDTH  iterations requested
- cfg_user  in  AXIS_USER_WIDTH  MM2S tuser value
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- iter_done  out  CNT_WIDTH  completed iterations
- err_count  out  CNT_WIDTH  statuses with nonzero error
- last_error  out  4  most recent nonzero error code
- s2mm_desc  out  AXI_ADDR_WIDTH+AXI_LEN_WIDTH  {len, addr}, addr in low bits
- s2mm_tag  out  TAG_WIDTH  iteration index, low bits
- s2mm_valid / s2mm_ready  out / in  1  descriptor handshake
- s2mm_status_tag  in  TAG_WIDTH  completion tag
- s2mm_status_error  in  4  completion error code
- s2mm_status_valid  in  1  completion strobe
- mm2s_desc  out  AXI_ADDR_WIDTH+AXI_LEN_WIDTH  {len, addr}
- mm2s_user  out  AXIS_USER_WIDTH  latched cfg_user
- mm2s_valid / mm2s_ready  out / in  1  descriptor handshake
- mm2s_status_error  in  4  completion error code
- mm2s_status_valid  in  1  completion strobe

## Operation
- States: IDLE, ISSUE_WR, ISSUE_RD, WAIT, FINISH.
- IDLE, on cfg_start:
  - Latch all cfg_* fields except cfg_abort.
  - Clear iter_done, err_count and last_error.
  - If cfg_count==0 or cfg_len==0, go to FINISH. Otherwise go to ISSUE_WR.
- ISSUE_WR: drive s2mm_valid with {len, dst_ptr} and tag = iter_done[TAG_WIDTH-1:0]. On s2mm_ready, go to ISSUE_RD.
- ISSUE_RD: drive mm2s_valid with {len, src_ptr}. On mm2s_ready, go to WAIT.
- WAIT:
  - Track wr_seen and rd_seen flags. Either status may arrive first, or both may arrive in the same cycle.
  - When both flags are set (counting a strobe in the current cycle):
    - Increment iter_done.
    - Add stride to src_ptr and dst_ptr. Addition wraps modulo 2^AXI_ADDR_WIDTH.
    - Clear the flags.
    - If iter_done+1==count or cfg_abort is high, go to FINISH. Otherwise go to ISSUE_WR.
- Error handling, per status strobe:
  - Nonzero error: err_count += 1 and last_error is updated.
  - Two erroring strobes in the same cycle: err_count += 2; last_error takes the S2MM code.
  - err_count saturates at all-ones.
  - Errors do not stop the sequence.
- Tag check: an s2mm_status_tag different from the expected tag counts as an error with last_error = 4'hF. The status still counts as received.
- Status strobes outside WAIT are ignored.
- FINISH: pulse done for 1 cycle, then go to IDLE.
- cfg_start while busy is ignored.
- cfg_abort is sampled only at iteration end. A descriptor handshake already presented is never withdrawn.

## Timing
- Reset values: busy=0, done=0, s2mm_valid=0, mm2s_valid=0, iter_done=0, err_count=0, last_error=0, all descriptor, tag and user outputs =0, state=IDLE.
- Reset mid-sequence returns to IDLE immediately. No descriptor is re-issued.
- All outputs are registered.
- Start pulse at cycle t: busy=1 and s2mm_valid=1 at t+1.
- S2MM handshake at cycle h: mm2s_valid=1 at h+1.
- Valid stays high with stable data until ready. Each descriptor handshake takes at least 1 cycle.
- Final status pair completes at cycle c: iter_done updates at c+1, done=1 at c+1, busy=0 at c+2.
- Degenerate start (count==0 or len==0) at cycle t: done at t+2 and no descriptors issued.
- Minimum iteration period with ready tied high and statuses arriving immediately: 3 cycles.

## Test plan
- src=0x1000, dst=0x8000, len=256, stride=0x100, count=3, readies tied 1, statuses returned 5 cycles after MM2S handshake:
  - S2MM descriptor addresses 0x8000, 0x8100, 0x8200; MM2S addresses 0x1000, 0x1100, 0x1200.
  - Tags 0, 1, 2; iter_done=3; one done pulse; err_count=0.
- s2mm_ready held low 10 cycles: s2mm_valid and s2mm_desc stay stable; mm2s_valid stays 0 until 1 cycle after the S2MM handshake.
- Status order: MM2S status before S2MM, then both in the same cycle on the next iteration: each iteration counted exactly once; iter_done=2 for count=2.
- Error codes: mm2s_status_error=2 on iteration 0, wrong s2mm_status_tag on iteration 1 → err_count=2, last_error=4'hF, sequence completes.
- cfg_abort raised during iteration 1 of count=5 → done after iteration 1 completes with iter_done=2; cfg_start while busy is ignored.
- Corner cases:
  - count=0 → done at t+2, no valids.
  - rstn pulsed low during WAIT → all outputs return to reset values; a new start runs normally.
  - dst=0xFFFFFF00 with stride 0x100 → second S2MM address 0x00000000.
